wb_spi_target: RTL and testbench
================================

WB_SPI_TARGET -- requirements
Module: wb_spi_target

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 16, the depth of each of the RX and TX FIFOs in bytes (power of two, minimum 4).
REQ-002 SHALL provide clk_i  input  1  the single system clock; all logic is on its rising edge.
REQ-003 SHALL provide rst_i  input  1  synchronous, active-high reset.
REQ-004 SHALL provide cyc_i  input  1  Wishbone cycle.
REQ-005 SHALL provide stb_i  input  1  Wishbone strobe.
REQ-006 SHALL provide adr_i  input  2  word address: 0=DATA, 1=STATUS/CTRL, 2-3 reserved.
REQ-007 SHALL provide we_i  input  1  write enable.
REQ-008 SHALL provide dat_i  input  32  write data; only byte lane [31:24] is used.
REQ-009 SHALL provide sel_i  input  4  byte selects; a write takes effect only when sel_i[3]=1.
REQ-010 SHALL provide ack_o  output  1  Wishbone acknowledge.
REQ-011 SHALL provide dat_o  output  32  read data in [31:24], with [23:0]=0.
REQ-012 SHALL provide sck  input  1  external SPI clock, asynchronous to clk_i.
REQ-013 SHALL provide ss  input  1  external active-low select, asynchronous to clk_i.
REQ-014 SHALL provide mosi  input  1  external serial data in, asynchronous to clk_i.
REQ-015 SHALL provide miso  output  1  serial data out.
REQ-016 SHALL provide irq_o  output  1  level interrupt.

Function
REQ-017 SHALL pass sck, ss and mosi each through a 2-flop synchronizer; edges are detected between the 2nd and a 3rd stage; sck frequency SHALL be at most clk_i/8.
REQ-018 SHALL implement SPI mode 0, MSB first, 8-bit frames: sample mosi on sck rise, shift miso on sck fall; sck edges are ignored while the synchronized ss is high.
REQ-019 SHALL clear the 3-bit bit counter on the falling edge of ss and load the TX shifter from the TX FIFO head (pop); if the TX FIFO is empty, it SHALL load 0xFF and set tx_underrun.
REQ-020 SHALL increment the bit counter on each sck rise; on the 8th rise the counter wraps to 0, the assembled byte is pushed to the RX FIFO, and the next TX byte is loaded as in REQ-019.
REQ-021 SHALL shift the TX shifter left on an sck fall only when the bit counter is nonzero.
REQ-022 SHALL drive miso = TX shifter[7] while the synchronized ss is low, else 0.
REQ-023 SHALL, when the RX FIFO is full at push time (count taken before any same-cycle pop), drop the byte and set rx_overrun.
REQ-024 SHALL, when ss rises mid-byte, discard the partial byte, push nothing, and clear the counter; the already-loaded TX byte is lost.
REQ-025 SHALL generate ack_o as: ack_o <= cyc_i & stb_i & !ack_o, giving a 1-cycle latency and no back-to-back acks; all register side effects occur in the ack_o cycle, exactly once per ack.
REQ-026 SHALL handle a DATA read by returning the RX head and popping it; when the RX FIFO is empty it SHALL return 0x00 and not pop.
REQ-027 SHALL handle a DATA write by pushing dat_i[31:24] to the TX FIFO; when the TX FIFO is full the write SHALL be dropped silently.
REQ-028 SHALL return the STATUS byte as: bit0 rx_not_empty, bit1 tx_full, bit2 ss_active (synchronized ss low), bit3 rx_overrun, bit4 tx_underrun, bit5 irq_en, bits 7:6 = 0.
REQ-029 SHALL handle a CTRL write as: bit3/bit4 write-1-to-clear the corresponding flag, bit5 loads irq_en, bit6 write-1 flushes both FIFOs (the flush takes priority over a same-cycle push or pop).
REQ-030 SHALL, when a flag is set and cleared in the same cycle, leave the flag set.
REQ-031 SHALL return 0 for reads of reserved addresses and ignore writes to them.
REQ-032 SHALL register irq_o = irq_en & rx_not_empty.

Reset
REQ-033 SHALL on rst_i reset ack_o=0, irq_o=0, miso=0, both FIFOs to empty, bit counter=0, TX shifter=0xFF, rx_overrun=0, tx_underrun=0, irq_en=0, and all synchronizer flops to ss=1, sck=0, mosi=0.
REQ-034 SHALL abandon any frame in progress when reset is asserted mid-transfer; receive restarts only after the next ss falling edge.

Verification
REQ-035 SHALL pass this scenario: write DATA 0xA5, then master sends 0x3C with sck=clk/8 -> miso bits 1,0,1,0,0,1,0,1, RX read returns 0x3C, and STATUS bit0 is 0 afterwards.
REQ-036 SHALL pass this scenario: TX FIFO empty, 2-byte transfer -> miso sends 0xFF twice, STATUS=0x14 during the transfer with ss low, write CTRL 0x10 -> bit4 is clear.
REQ-037 SHALL pass this scenario: FIFO_DEPTH+1 bytes received with no reads -> first FIFO_DEPTH bytes are read back in order, the last byte is dropped, and bit3 is set.
REQ-038 SHALL pass this scenario: ss deasserted after 5 bits, then a full byte 0x81 -> only 0x81 is in the RX FIFO.
REQ-039 SHALL pass this scenario: irq_en=1, one byte received -> irq_o rises within 1 cycle of the push and falls 1 cycle after the DATA read ack.
REQ-040 SHALL pass this scenario: CTRL write 0x40 with both FIFOs nonempty -> STATUS reads 0x00 with ss high.

Source files
------------

// File: rtl/wb_spi_target.sv
// Wishbone-attached SPI target (mode 0, MSB first, 8-bit frames) with RX/TX byte FIFOs.
// Ports:
//   clk_i, rst_i         system clock, synchronous active-high reset
//   cyc_i, stb_i, adr_i, we_i, dat_i, sel_i, ack_o, dat_o
//                        Wishbone slave; adr 0 = DATA, 1 = STATUS/CTRL, byte lane [31:24]
//   sck, ss, mosi, miso  SPI target pins (sck/ss/mosi asynchronous to clk_i)
//   irq_o                level interrupt: irq_en & rx_not_empty
module wb_spi_target #(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic [1:0]  adr_i,
    input  logic        we_i,
    input  logic [31:0] dat_i,
    input  logic [3:0]  sel_i,
    output logic        ack_o,
    output logic [31:0] dat_o,
    input  logic        sck,
    input  logic        ss,
    input  logic        mosi,
    output logic        miso,
    output logic        irq_o
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [2:0]    sck_q;
    logic [2:0]    ss_q;
    logic [1:0]    mosi_q;
    logic [2:0]    bit_cnt;
    logic [6:0]    rx_shift;
    logic [7:0]    tx_shift;
    logic [7:0]    tx_shift_d;
    logic          rx_overrun;
    logic          tx_underrun;
    logic          irq_en;

    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_rd, rx_wr, tx_rd, tx_wr;
    logic [CW-1:0] rx_cnt, tx_cnt;

    logic ss_low, ss_fall, ss_rise, sck_rise, sck_fall, byte_done;
    logic rx_full, rx_empty, tx_full, tx_empty;
    logic tx_load, tx_pop, rx_push_ok, rx_pop, tx_push;
    logic wb_fire, ctrl_wr, data_wr, flush;
    logic [7:0] status, rd_byte;
    logic unused_ok;

    assign unused_ok = ^{dat_i[23:0], sel_i[2:0]};

    // Edge detection between the 2nd and 3rd synchronizer stages
    assign ss_low    = ~ss_q[1];
    assign ss_fall   = ss_q[2] & ~ss_q[1];
    assign ss_rise   = ~ss_q[2] & ss_q[1];
    assign sck_rise  = ss_low & sck_q[1] & ~sck_q[2];
    assign sck_fall  = ss_low & ~sck_q[1] & sck_q[2];
    assign byte_done = sck_rise & (bit_cnt == 3'd7);

    assign rx_full  = (rx_cnt == CW'(FIFO_DEPTH));
    assign rx_empty = (rx_cnt == '0);
    assign tx_full  = (tx_cnt == CW'(FIFO_DEPTH));
    assign tx_empty = (tx_cnt == '0);

    // Wishbone side effects happen on the edge that raises ack_o
    assign wb_fire = cyc_i & stb_i & ~ack_o;
    assign data_wr = wb_fire & we_i & sel_i[3] & (adr_i == 2'd0);
    assign ctrl_wr = wb_fire & we_i & sel_i[3] & (adr_i == 2'd1);
    assign flush   = ctrl_wr & dat_i[30];

    assign tx_load    = ss_fall | byte_done;
    assign tx_pop     = tx_load & ~tx_empty & ~flush;
    assign tx_push    = data_wr & ~tx_full & ~flush;
    assign rx_push_ok = byte_done & ~rx_full & ~flush;
    assign rx_pop     = wb_fire & ~we_i & (adr_i == 2'd0) & ~rx_empty & ~flush;

    assign status = {2'b00, irq_en, tx_underrun, rx_overrun, ss_low, tx_full, ~rx_empty};

    // Read mux
    always_comb begin
        rd_byte = 8'h00;
        case (adr_i)
            2'd0:    rd_byte = rx_empty ? 8'h00 : rx_mem[rx_rd];
            2'd1:    rd_byte = status;
            default: rd_byte = 8'h00;
        endcase
    end

    // TX shifter next value; miso is registered from it so it tracks the shifter without lag
    always_comb begin
        tx_shift_d = tx_shift;
        if (tx_load) begin
            tx_shift_d = tx_pop ? tx_mem[tx_rd] : 8'hFF;
        end else if (sck_fall && (bit_cnt != 3'd0)) begin
            tx_shift_d = {tx_shift[6:0], 1'b0};
        end
    end

    // FIFO storage (no reset needed; validity tracked by pointers/counts)
    always_ff @(posedge clk_i) begin
        if (rx_push_ok) rx_mem[rx_wr] <= {rx_shift, mosi_q[1]};
        if (tx_push)    tx_mem[tx_wr] <= dat_i[31:24];
    end

    // Control and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_q       <= 3'b000;
            ss_q        <= 3'b111;
            mosi_q      <= 2'b00;
            bit_cnt     <= 3'd0;
            rx_shift    <= 7'd0;
            tx_shift    <= 8'hFF;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
            irq_en      <= 1'b0;
            rx_rd       <= '0;
            rx_wr       <= '0;
            rx_cnt      <= '0;
            tx_rd       <= '0;
            tx_wr       <= '0;
            tx_cnt      <= '0;
            ack_o       <= 1'b0;
            dat_o       <= 32'd0;
            miso        <= 1'b0;
            irq_o       <= 1'b0;
        end else begin
            sck_q  <= {sck_q[1:0], sck};
            ss_q   <= {ss_q[1:0], ss};
            mosi_q <= {mosi_q[0], mosi};

            // Either ss edge restarts framing; a partial byte is simply abandoned
            if (ss_fall || ss_rise) begin
                bit_cnt <= 3'd0;
            end else if (sck_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (sck_rise) rx_shift <= {rx_shift[5:0], mosi_q[1]};
            tx_shift <= tx_shift_d;
            miso     <= ss_low & tx_shift_d[7];

            if (flush) begin
                rx_rd  <= '0;
                rx_wr  <= '0;
                rx_cnt <= '0;
                tx_rd  <= '0;
                tx_wr  <= '0;
                tx_cnt <= '0;
            end else begin
                if (rx_push_ok) rx_wr <= rx_wr + AW'(1);
                if (rx_pop)     rx_rd <= rx_rd + AW'(1);
                rx_cnt <= rx_cnt + CW'(rx_push_ok) - CW'(rx_pop);
                if (tx_push)    tx_wr <= tx_wr + AW'(1);
                if (tx_pop)     tx_rd <= tx_rd + AW'(1);
                tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
            end

            // Set wins over a same-cycle write-1-to-clear
            rx_overrun  <= (byte_done & rx_full) |
                           (rx_overrun & ~(ctrl_wr & dat_i[27]));
            tx_underrun <= (tx_load & tx_empty) |
                           (tx_underrun & ~(ctrl_wr & dat_i[28]));
            if (ctrl_wr) irq_en <= dat_i[29];

            ack_o <= wb_fire;
            dat_o <= wb_fire ? {rd_byte, 24'd0} : 32'd0;
            irq_o <= irq_en & ~rx_empty;
        end
    end
endmodule

// File: tb/tb_wb_spi_target.sv
// Directed bench for wb_spi_target: queue-based model of the FIFOs/flags plus hand-computed literals.
module tb_wb_spi_target;
    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst, cyc, stb, we, ack, sck, ss, mosi, miso, irq;
    logic [1:0]  adr;
    logic [31:0] dat_w, dat_r;
    logic [3:0]  sel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_spi_target #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .adr_i(adr), .we_i(we),
        .dat_i(dat_w), .sel_i(sel), .ack_o(ack), .dat_o(dat_r),
        .sck(sck), .ss(ss), .mosi(mosi), .miso(miso), .irq_o(irq)
    );

    // Model state
    logic [7:0] rx_q [$];
    logic [7:0] tx_q [$];
    logic       m_over = 1'b0, m_under = 1'b0, m_irq_en = 1'b0;
    logic [7:0] cur_tx = 8'hFF;
    logic       m_ack = 1'b0;
    logic       chk_rd = 1'b0;
    logic [7:0] exp_rd = 8'h00;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] m_status();
        return {2'b00, m_irq_en, m_under, m_over, ~ss,
                (tx_q.size() == int'(DEPTH)), (rx_q.size() != 0)};
    endfunction

    function automatic logic [7:0] m_read(input logic [1:0] a);
        if (a == 2'd0) return (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        if (a == 2'd1) return m_status();
        return 8'h00;
    endfunction

    // Acknowledge protocol model: one-cycle latency, never back-to-back
    always @(posedge clk) m_ack <= rst ? 1'b0 : (cyc & stb & ~m_ack);

    // Per-cycle compare against the model
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            check("ack", 32'(ack), 32'(m_ack));
            if (ack && chk_rd) check("rdata", dat_r, {exp_rd, 24'h0});
        end
    end

    task automatic wb_cycle(input logic [1:0] a, input logic w, input logic [7:0] d,
                            input logic [3:0] s, output logic [7:0] got);
        int n;
        @(negedge clk);
        adr = a; we = w; dat_w = {d, 24'h0}; sel = s;
        if (!w) begin
            exp_rd = m_read(a);
            chk_rd = 1'b1;
        end
        cyc = 1'b1; stb = 1'b1;
        n = 0;
        while (!ack && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (!ack) begin
            total++; bad++;
            $display("FAIL ack_timeout got=0 exp=1");
        end
        got = dat_r[31:24];
        cyc = 1'b0; stb = 1'b0; chk_rd = 1'b0;
        if (!w && a == 2'd0 && rx_q.size() != 0) void'(rx_q.pop_front());
        if (w && s[3]) begin
            if (a == 2'd0 && tx_q.size() < int'(DEPTH)) tx_q.push_back(d);
            if (a == 2'd1) begin
                if (d[6]) begin
                    rx_q.delete();
                    tx_q.delete();
                end
                if (d[3]) m_over = 1'b0;
                if (d[4]) m_under = 1'b0;
                m_irq_en = d[5];
            end
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] got);
        wb_cycle(a, 1'b0, 8'h00, 4'hF, got);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d, input logic [3:0] s);
        logic [7:0] dummy;
        wb_cycle(a, 1'b1, d, s, dummy);
    endtask

    task automatic load_tx();
        if (tx_q.size() != 0) cur_tx = tx_q.pop_front();
        else begin
            cur_tx  = 8'hFF;
            m_under = 1'b1;
        end
    endtask

    task automatic spi_begin();
        @(negedge clk);
        ss = 1'b0;
        load_tx();
        repeat (8) @(negedge clk);
    endtask

    // Master side: sck = clk/8, miso sampled just before each rising edge
    task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] seen);
        seen = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = b[7 - i];
            repeat (4) @(negedge clk);
            seen = {seen[6:0], miso};
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] seen);
        logic [7:0] exp;
        exp = cur_tx;
        spi_bits(b, 8, seen);
        check("miso_byte", 32'(seen), 32'(exp));
        if (rx_q.size() < int'(DEPTH)) rx_q.push_back(b);
        else m_over = 1'b1;
        load_tx();
    endtask

    task automatic spi_end();
        repeat (4) @(negedge clk);
        ss = 1'b1; mosi = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic check_idle();
        repeat (3) @(negedge clk);
        check("irq_idle", 32'(irq), 32'(m_irq_en && rx_q.size() != 0));
        check("miso_idle", 32'(miso), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] g, s;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; adr = 2'd0; we = 1'b0;
        dat_w = 32'd0; sel = 4'h0; sck = 1'b0; ss = 1'b1; mosi = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_miso", 32'(miso), 32'd0);
        rst = 1'b0;
        rd(2'd1, g); check("rst_status", 32'(g), 32'h00);

        // Preloaded TX byte goes out while 0x3C comes in
        wr(2'd0, 8'hA5, 4'hF);
        spi_begin(); spi_byte(8'h3C, s); spi_end();
        check("miso_a5", 32'(s), 32'hA5);
        rd(2'd0, g); check("rx_3c", 32'(g), 32'h3C);
        rd(2'd1, g); check("rx_empty_bit", 32'(g[0]), 32'd0);
        check_idle();
        wr(2'd1, 8'h18, 4'hF);

        // Empty TX: idle 0xFF, underrun visible with ss low
        spi_begin();
        rd(2'd1, g); check("status_14", 32'(g), 32'h14);
        spi_byte(8'h12, s); check("miso_ff0", 32'(s), 32'hFF);
        spi_byte(8'h34, s); check("miso_ff1", 32'(s), 32'hFF);
        spi_end();
        wr(2'd1, 8'h10, 4'hF);
        rd(2'd1, g); check("underrun_clr", 32'(g), 32'h01);
        rd(2'd0, g); rd(2'd0, g); check("rx_34", 32'(g), 32'h34);

        // RX overflow: DEPTH+1 bytes, last one dropped
        spi_begin();
        for (int i = 0; i <= int'(DEPTH); i++) spi_byte(8'(i * 7 + 1), s);
        spi_end();
        rd(2'd1, g); check("overrun_set", 32'(g[3]), 32'd1);
        for (int i = 0; i < int'(DEPTH); i++) begin
            rd(2'd0, g);
            if (i == 0) check("rx_first", 32'(g), 32'h01);
        end
        check("rx_last", 32'(g), 32'h6A);
        rd(2'd0, g); check("rx_empty_read", 32'(g), 32'h00);
        wr(2'd1, 8'h18, 4'hF);

        // TX full, then flush with both FIFOs nonempty
        for (int i = 0; i <= int'(DEPTH); i++) wr(2'd0, 8'(8'h50 + i), 4'hF);
        rd(2'd1, g); check("tx_full", 32'(g[1]), 32'd1);
        spi_begin(); spi_byte(8'h77, s); spi_end();
        check("miso_50", 32'(s), 32'h50);
        wr(2'd1, 8'h40, 4'hF);
        rd(2'd1, g); check("flush_status", 32'(g), 32'h00);
        spi_begin(); spi_byte(8'h99, s); spi_end();
        check("miso_after_flush", 32'(s), 32'hFF);
        rd(2'd0, g); check("rx_99", 32'(g), 32'h99);
        wr(2'd1, 8'h18, 4'hF);

        // Aborted partial byte is discarded
        spi_begin(); spi_bits(8'hF0, 5, s); spi_end();
        spi_begin(); spi_byte(8'h81, s); spi_end();
        rd(2'd0, g); check("rx_81", 32'(g), 32'h81);
        rd(2'd1, g); check("rx_only_81", 32'(g[0]), 32'd0);

        // sel_i[3]=0 write and reserved addresses have no effect
        wr(2'd0, 8'h5A, 4'b0111);
        wr(2'd2, 8'hFF, 4'hF);
        rd(2'd3, g); check("rsvd3", 32'(g), 32'h00);
        rd(2'd2, g); check("rsvd2", 32'(g), 32'h00);
        rd(2'd1, g); check("irq_en_untouched", 32'(g[5]), 32'd0);
        spi_begin(); spi_byte(8'h00, s); spi_end();
        check("sel_ignored", 32'(s), 32'hFF);
        rd(2'd0, g);
        wr(2'd1, 8'h18, 4'hF);

        // Interrupt: rises after push, falls one cycle after read ack
        wr(2'd1, 8'h20, 4'hF);
        spi_begin(); spi_byte(8'hC3, s); spi_end();
        check_idle();
        @(negedge clk);
        adr = 2'd0; we = 1'b0; sel = 4'hF; exp_rd = m_read(2'd0); chk_rd = 1'b1;
        cyc = 1'b1; stb = 1'b1;
        for (int n = 0; n < 16 && !ack; n++) @(negedge clk);
        check("irq_ack_seen", 32'(ack), 32'd1);
        check("irq_at_ack", 32'(irq), 32'd1);
        cyc = 1'b0; stb = 1'b0; chk_rd = 1'b0;
        void'(rx_q.pop_front());
        @(negedge clk);
        check("irq_after_ack", 32'(irq), 32'd0);
        check_idle();

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
